// File: rtl/xmega_core.sv
// rtl/xmega_core.sv - single-issue AVR/XMEGA instruction-subset core
module xmega_core #(
  parameter int bus_addr_pgm_width  = 11,
  parameter int bus_addr_data_width = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [bus_addr_pgm_width-1:0]  pgm_addr,
  input  logic [15:0]                    pgm_data,
  output logic                           data_re,
  output logic                           data_we,
  output logic [bus_addr_data_width-1:0] data_addr,
  input  logic [7:0]                     data_in,
  output logic [7:0]                     data_out,
  output logic                           io_re,
  output logic                           io_we,
  output logic [5:0]                     io_addr,
  output logic [7:0]                     io_out,
  input  logic [7:0]                     io_in
);

  localparam int PW = bus_addr_pgm_width;
  localparam int DW = bus_addr_data_width;

  logic [PW-1:0] r_pc;
  logic [7:0]    r_regs [32];
  logic          r_c, r_z, r_n;
  logic          r_ld_busy;

  logic [15:0]   w_ir;
  logic [4:0]    w_d, w_r, w_widx;
  logic [7:0]    w_rd_val, w_rr_val, w_wval, w_res;
  logic [8:0]    w_sum9, w_sub9;
  logic [31:0]   w_k12, w_k7;
  logic [PW-1:0] w_pc_inc, w_pc_rjmp, w_pc_br, w_pc_next;
  logic          w_we, w_set_zn, w_c, w_z, w_n, w_ld_next, w_br_flag;
  logic          w_data_re, w_data_we, w_io_re, w_io_we;
  logic [DW-1:0] w_data_addr;
  logic [7:0]    w_data_out, w_io_out;
  logic [5:0]    w_io_addr;

  assign w_ir     = pgm_data;
  assign w_d      = w_ir[8:4];
  assign w_r      = {w_ir[9], w_ir[3:0]};
  assign w_rd_val = r_regs[w_d];
  assign w_rr_val = r_regs[w_r];
  // ADC differs from ADD only in opcode bit 12, which gates the carry-in
  assign w_sum9   = {1'b0, w_rd_val} + {1'b0, w_rr_val} + {8'd0, w_ir[12] & r_c};
  assign w_sub9   = {1'b0, w_rd_val} - {1'b0, w_rr_val};
  assign w_k12    = {{20{w_ir[11]}}, w_ir[11:0]};
  assign w_k7     = {{25{w_ir[9]}}, w_ir[9:3]};
  assign w_pc_inc  = r_pc + PW'(1);
  assign w_pc_rjmp = w_pc_inc + w_k12[PW-1:0];
  assign w_pc_br   = w_pc_inc + w_k7[PW-1:0];
  // bit 0 of the status-bit field selects Z (1) or C (0)
  assign w_br_flag = w_ir[0] ? r_z : r_c;

  // decode the current instruction into next-state values and bus strobes
  always_comb begin
    w_we        = 1'b0;
    w_widx      = w_d;
    w_wval      = 8'h00;
    w_res       = 8'h00;
    w_set_zn    = 1'b0;
    w_c         = r_c;
    w_z         = r_z;
    w_n         = r_n;
    w_pc_next   = w_pc_inc;
    w_ld_next   = 1'b0;
    w_data_re   = 1'b0;
    w_data_we   = 1'b0;
    w_data_addr = '0;
    w_data_out  = 8'h00;
    w_io_re     = 1'b0;
    w_io_we     = 1'b0;
    w_io_addr   = 6'd0;
    w_io_out    = 8'h00;
    casez (w_ir)
      16'b1110_????_????_????: begin
        w_we = 1'b1; w_widx = {1'b1, w_ir[7:4]}; w_wval = {w_ir[11:8], w_ir[3:0]};
      end
      16'b0000_11??_????_????, 16'b0001_11??_????_????: begin
        w_res = w_sum9[7:0]; w_we = 1'b1; w_wval = w_res; w_c = w_sum9[8]; w_set_zn = 1'b1;
      end
      16'b0001_10??_????_????: begin
        w_res = w_sub9[7:0]; w_we = 1'b1; w_wval = w_res; w_c = w_sub9[8]; w_set_zn = 1'b1;
      end
      16'b0001_01??_????_????: begin
        w_res = w_sub9[7:0]; w_c = w_sub9[8]; w_set_zn = 1'b1;
      end
      16'b0010_00??_????_????: begin
        w_res = w_rd_val & w_rr_val; w_we = 1'b1; w_wval = w_res; w_set_zn = 1'b1;
      end
      16'b0010_01??_????_????: begin
        w_res = w_rd_val ^ w_rr_val; w_we = 1'b1; w_wval = w_res; w_set_zn = 1'b1;
      end
      16'b0010_10??_????_????: begin
        w_res = w_rd_val | w_rr_val; w_we = 1'b1; w_wval = w_res; w_set_zn = 1'b1;
      end
      16'b0010_11??_????_????: begin
        w_we = 1'b1; w_wval = w_rr_val;
      end
      16'b1001_010?_????_0011: begin
        w_res = w_rd_val + 8'd1; w_we = 1'b1; w_wval = w_res; w_set_zn = 1'b1;
      end
      16'b1001_010?_????_1010: begin
        w_res = w_rd_val - 8'd1; w_we = 1'b1; w_wval = w_res; w_set_zn = 1'b1;
      end
      16'b1100_????_????_????: w_pc_next = w_pc_rjmp;
      16'b1111_00??_????_?00?: if (w_br_flag)  w_pc_next = w_pc_br;
      16'b1111_01??_????_?00?: if (!w_br_flag) w_pc_next = w_pc_br;
      16'b1011_0???_????_????: begin
        w_io_re = 1'b1; w_io_addr = {w_ir[10:9], w_ir[3:0]}; w_we = 1'b1; w_wval = io_in;
      end
      16'b1011_1???_????_????: begin
        w_io_we = 1'b1; w_io_addr = {w_ir[10:9], w_ir[3:0]}; w_io_out = w_rd_val;
      end
      16'b1001_000?_????_1100: begin
        // first cycle issues the read and holds PC; second cycle retires it
        if (!r_ld_busy) begin
          w_data_re = 1'b1; w_data_addr = DW'(r_regs[26]); w_pc_next = r_pc; w_ld_next = 1'b1;
        end else begin
          w_we = 1'b1; w_wval = data_in;
        end
      end
      16'b1001_001?_????_1100: begin
        w_data_we = 1'b1; w_data_addr = DW'(r_regs[26]); w_data_out = w_rd_val;
      end
      default: ;
    endcase
    if (w_set_zn) begin
      w_z = (w_res == 8'h00);
      w_n = w_res[7];
    end
  end

  // architectural state update; reset also aborts an LD in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 8'h00;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_ld_busy <= 1'b0;
    end else begin
      r_pc      <= w_pc_next;
      if (w_we) r_regs[w_widx] <= w_wval;
      r_c       <= w_c;
      r_z       <= w_z;
      r_n       <= w_n;
      r_ld_busy <= w_ld_next;
    end
  end

  // buses are forced idle while reset is low, independent of the clock
  assign pgm_addr  = r_pc;
  assign data_re   = w_data_re & rst;
  assign data_we   = w_data_we & rst;
  assign data_addr = rst ? w_data_addr : '0;
  assign data_out  = rst ? w_data_out  : 8'h00;
  assign io_re     = w_io_re & rst;
  assign io_we     = w_io_we & rst;
  assign io_addr   = rst ? w_io_addr : 6'd0;
  assign io_out    = rst ? w_io_out  : 8'h00;

endmodule

// File: tb/tb_xmega_core.sv
// tb/tb_xmega_core.sv - self-checking bench for xmega_core
module tb_xmega_core;
  localparam int PW = 11;
  localparam int DW = 8;
  localparam logic [15:0] HALT = 16'hCFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [PW-1:0] pgm_addr;
  logic [15:0] pgm_data;
  logic data_re, data_we, io_re, io_we;
  logic [DW-1:0] data_addr;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out, io_out, io_in;
  logic [5:0] io_addr;

  logic [15:0] rom [0:2047];
  logic [7:0]  ram [0:255];

  typedef struct { logic mem; logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t q[$];

  typedef struct {
    int kind; logic [7:0] a; logic [7:0] b; logic cin; logic same;
    logic [7:0] res; logic c; logic z; logic n;
  } vec_t;
  vec_t vecs[13];

  int n_cmp = 0;
  int n_bad = 0;
  int n_at1 = 0;
  int n_io_re = 0;

  always #5 clk = ~clk;

  xmega_core #(.bus_addr_pgm_width(PW), .bus_addr_data_width(DW)) dut (
    .clk(clk), .rst(rst), .pgm_addr(pgm_addr), .pgm_data(pgm_data),
    .data_re(data_re), .data_we(data_we), .data_addr(data_addr),
    .data_in(data_in), .data_out(data_out), .io_re(io_re), .io_we(io_we),
    .io_addr(io_addr), .io_out(io_out), .io_in(io_in)
  );

  assign pgm_data = rom[pgm_addr];
  assign io_in = io_re ? (8'hAA ^ {2'b00, io_addr}) : 8'h00;

  always @(posedge clk) begin
    if (data_we) ram[data_addr] <= data_out;
    data_in <= data_re ? ram[data_addr] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic m, input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.mem = m; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic sb_pop(input logic m, input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb unexpected write: got mem=%0d addr=%0h data=%0h expected none", m, a, d);
    end else begin
      e = q.pop_front();
      check("sb kind", {31'd0, m}, {31'd0, e.mem});
      check("sb addr", {24'd0, a}, {24'd0, e.addr});
      check("sb data", {24'd0, d}, {24'd0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (io_we)   sb_pop(1'b0, {2'b00, io_addr}, io_out);
      if (data_we) sb_pop(1'b1, data_addr, data_out);
      if (io_re)   n_io_re++;
      if (pgm_addr == 11'd1) n_at1++;
    end
  end

  function automatic logic [15:0] ldi(input logic [4:0] d, input logic [7:0] k);
    return {4'b1110, k[7:4], d[3:0], k[3:0]};
  endfunction
  function automatic logic [15:0] rr(input logic [5:0] op, input logic [4:0] d, input logic [4:0] r);
    return {op, r[4], d, r[3:0]};
  endfunction
  function automatic logic [15:0] op_out(input logic [5:0] a, input logic [4:0] r);
    return {5'b10111, a[5:4], r, a[3:0]};
  endfunction
  function automatic logic [15:0] op_in(input logic [4:0] d, input logic [5:0] a);
    return {5'b10110, a[5:4], d, a[3:0]};
  endfunction
  function automatic logic [15:0] br(input logic clr, input logic [6:0] k, input logic zsel);
    return {5'b11110, clr, k, 2'b00, zsel};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = HALT;
    q.delete();
    n_at1 = 0;
    n_io_re = 0;
  endtask

  task automatic start();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic finish_prog(input int cycles, input string name);
    repeat (cycles) @(posedge clk);
    #1 check(name, q.size(), 0);
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [15:0] w_op;
    logic [4:0]  r_src;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    vecs[0]  = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{2, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{0, 8'h81, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3, 8'h10, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{4, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{5, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{6, 8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{7, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{8, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{9, 8'h11, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0};

    // reset state, with an OUT sitting at address 0
    clear_rom();
    rom[0] = op_out(6'h3F, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst pgm_addr", pgm_addr, 0);
    check("rst strobes", {data_re, data_we, io_re, io_we}, 0);
    check("rst data_addr", data_addr, 0);
    check("rst data_out", data_out, 0);
    check("rst io_addr", io_addr, 0);
    check("rst io_out", io_out, 0);

    // ALU table: set operands and carry-in, run op, read back result, C and Z
    foreach (vecs[i]) begin
      v = vecs[i];
      clear_rom();
      r_src = v.same ? 5'd16 : 5'd17;
      case (v.kind)
        0: w_op = rr(6'b000011, 5'd16, r_src);
        1: w_op = rr(6'b000111, 5'd16, r_src);
        2: w_op = rr(6'b000110, 5'd16, r_src);
        3: w_op = rr(6'b000101, 5'd16, r_src);
        4: w_op = rr(6'b001000, 5'd16, r_src);
        5: w_op = rr(6'b001010, 5'd16, r_src);
        6: w_op = rr(6'b001001, 5'd16, r_src);
        7: w_op = {7'b1001010, 5'd16, 4'b0011};
        8: w_op = {7'b1001010, 5'd16, 4'b1010};
        default: w_op = rr(6'b001011, 5'd16, r_src);
      endcase
      rom[0]  = ldi(5'd16, v.a);
      rom[1]  = ldi(5'd17, v.b);
      rom[2]  = ldi(5'd18, v.cin ? 8'hFF : 8'h00);
      rom[3]  = ldi(5'd19, 8'h01);
      rom[4]  = rr(6'b000011, 5'd18, 5'd19);
      rom[5]  = w_op;
      rom[6]  = ldi(5'd20, 8'h00);
      rom[7]  = br(1'b1, 7'd1, 1'b0);
      rom[8]  = ldi(5'd20, 8'h01);
      rom[9]  = ldi(5'd21, 8'h00);
      rom[10] = br(1'b1, 7'd1, 1'b1);
      rom[11] = ldi(5'd21, 8'h01);
      rom[12] = op_out(6'd1, 5'd16);
      rom[13] = op_out(6'd2, 5'd20);
      rom[14] = op_out(6'd3, 5'd21);
      push(1'b0, 8'd1, v.res);
      push(1'b0, 8'd2, {7'd0, v.c});
      push(1'b0, 8'd3, {7'd0, v.z});
      start();
      repeat (20) @(posedge clk);
      #1 check($sformatf("alu%0d N", i), {31'd0, dut.r_n}, {31'd0, v.n});
      finish_prog(0, $sformatf("alu%0d drain", i));
    end

    // LDI; OUT: io_we on the second cycle only
    clear_rom();
    rom[0] = ldi(5'd16, 8'h55);
    rom[1] = op_out(6'd0, 5'd16);
    push(1'b0, 8'h00, 8'h55);
    start();
    @(negedge clk) check("out c0 io_we", io_we, 0);
    @(negedge clk) check("out c1 io_we", io_we, 1);
    @(negedge clk) check("out c2 io_we", io_we, 0);
    finish_prog(3, "out drain");

    // IN captures io_in; two addresses exercise the split A field
    clear_rom();
    rom[0] = op_in(5'd17, 6'd0);
    rom[1] = op_out(6'd0, 5'd17);
    rom[2] = op_in(5'd18, 6'h2A);
    rom[3] = op_out(6'h3F, 5'd18);
    push(1'b0, 8'h00, 8'hAA);
    push(1'b0, 8'h3F, 8'h80);
    start();
    @(negedge clk) check("in c0 io_re/addr", {io_re, io_we, io_addr}, {1'b1, 1'b0, 6'd0});
    @(negedge clk) check("in c1 io_re", io_re, 0);
    finish_prog(6, "in drain");
    check("in io_re count", n_io_re, 2);

    // DEC/BRNE loop
    clear_rom();
    rom[0] = ldi(5'd16, 8'h03);
    rom[1] = {7'b1001010, 5'd16, 4'b1010};
    rom[2] = br(1'b1, 7'b1111110, 1'b1);
    rom[3] = ldi(5'd21, 8'h00);
    rom[4] = br(1'b1, 7'd1, 1'b1);
    rom[5] = ldi(5'd21, 8'h01);
    rom[6] = op_out(6'd1, 5'd16);
    rom[7] = op_out(6'd3, 5'd21);
    push(1'b0, 8'd1, 8'h00);
    push(1'b0, 8'd3, 8'h01);
    start();
    repeat (7) @(posedge clk);
    #1 check("loop exit pc", pgm_addr, 3);
    finish_prog(9, "loop drain");
    check("loop body count", n_at1, 3);

    // ST then LD through X; PC held for one cycle
    clear_rom();
    rom[0] = ldi(5'd26, 8'h10);
    rom[1] = ldi(5'd16, 8'h3C);
    rom[2] = {7'b1001001, 5'd16, 4'b1100};
    rom[3] = {7'b1001000, 5'd18, 4'b1100};
    rom[4] = op_out(6'd1, 5'd18);
    push(1'b1, 8'h10, 8'h3C);
    push(1'b0, 8'd1, 8'h3C);
    start();
    repeat (3) @(posedge clk);
    @(negedge clk) check("ld c1", {pgm_addr, data_re, data_addr}, {11'd3, 1'b1, 8'h10});
    @(negedge clk) check("ld c2", {pgm_addr, data_re, data_addr}, {11'd3, 1'b0, 8'h00});
    @(negedge clk) check("ld done pc", pgm_addr, 4);
    finish_prog(3, "ld drain");

    // reset in LD cycle 1 aborts the load and clears state asynchronously
    clear_rom();
    rom[0] = ldi(5'd26, 8'h10);
    rom[1] = ldi(5'd18, 8'h77);
    rom[2] = {7'b1001000, 5'd18, 4'b1100};
    start();
    repeat (2) @(posedge clk);
    @(negedge clk) check("abort pre", {pgm_addr, data_re}, {11'd2, 1'b1});
    #1 rst = 1'b0;
    #1 check("abort async", {pgm_addr, data_re, data_addr}, {11'd0, 1'b0, 8'h00});
    clear_rom();
    rom[0] = op_out(6'd1, 5'd18);
    rom[1] = op_out(6'd2, 5'd26);
    push(1'b0, 8'd1, 8'h00);
    push(1'b0, 8'd2, 8'h00);
    start();
    finish_prog(5, "abort drain");

    // PC wraps below 0 via RJMP and back to 0 after the top address
    clear_rom();
    rom[0] = op_out(6'd5, 5'd16);
    rom[1] = 16'hCFFD;
    rom[2047] = ldi(5'd16, 8'h5A);
    push(1'b0, 8'd5, 8'h00);
    push(1'b0, 8'd5, 8'h5A);
    push(1'b0, 8'd5, 8'h5A);
    start();
    finish_prog(7, "wrap drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
